inv_key_schedule: RTL and testbench
===================================

Name: inv_key_schedule

Overview:
Sequential inverse AES-128 key schedule for decryption with on-the-fly keys. Takes the final round key (round 10) and emits round keys 10 down to 0, one per accepted handshake, using a single 4-instance s_box datapath. It feeds the decryption round pipeline so that the design does not need to store all 11 forward-expanded keys.

Parameters:
numKeys, 11, total round keys emitted (index numKeys-1 down to 0); only 11 is supported, which sizes the 4-bit index and the Rcon table (10 entries).

Ports:
CLK  input  1  system clock, rising edge
nRESET  input  1  asynchronous active-low reset
start  input  1  single-cycle request; loads lastRoundKey when the block is idle
lastRoundKey  input  128  round-10 key; word0 at [127:96], word3 at [31:0]
keyReady  input  1  consumer can accept roundKeyOutput this cycle
roundKeyOutput  output  128  current round key, same word order as lastRoundKey
roundKeyValid  output  1  roundKeyOutput/roundIndex are valid
roundIndex  output  4  round number of roundKeyOutput (10..0)
busy  output  1  high from the cycle after start is accepted until the last handshake
done  output  1  one-cycle pulse the cycle after key 0 is accepted

Behaviour:
- Reset (nRESET low, asynchronous): state=IDLE; roundKeyOutput=0, roundIndex=0, roundKeyValid=0, busy=0, done=0. Asserting reset mid-run aborts the run immediately and emits no further keys.
- IDLE: roundKeyValid=0. When start=1, register lastRoundKey into roundKeyOutput, set roundIndex=10, set roundKeyValid=1 and busy=1, and go to RUN. Latency is 1 cycle from start to the first valid key.
- RUN: roundKeyValid=1. Output is held stable while keyReady=0; there is no timeout.
- Handshake = roundKeyValid & keyReady on a rising edge.
  - With roundIndex>0: load the previous key and decrement roundIndex. The next key is valid in the following cycle, so back-to-back acceptance gives 1 key per cycle.
  - With roundIndex=0: go to IDLE; roundKeyValid=0, busy=0, done=1 for exactly one cycle. roundKeyOutput and roundIndex hold their last values.
- start while busy (RUN): ignored; no restart and no key reload.
- start in the same cycle that done pulses: the block is already IDLE, so start is accepted and the next run begins on the following cycle.
- Inverse step: current key K = w0|w1|w2|w3, with w0 at [127:96]; i = roundIndex-1 (0..9).
  - p3 = w3 ^ w2; p2 = w2 ^ w1; p1 = w1 ^ w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon[i].
  - RotWord(x) = {x[23:0], x[31:24]}. SubWord applies s_box (ports sboxInput/sboxOutput) to each byte.
  - Rcon[i] = {01,02,04,08,10,20,40,80,1b,36}[i] << 24.
  - Previous key = {p0, p1, p2, p3}.
- Datapath: combinational from the registered roundKeyOutput, 4 s_box instances, no multicycle paths. All state updates on the CLK rising edge except the asynchronous reset.
- roundIndex never underflows. Keys 10..0 are emitted exactly once each per run, in strictly descending order.

Test Plan:
- FIPS-197 A.1: start with lastRoundKey=d014f9a8c9ee2589e13f0cc8b6630ca6, keyReady=1.
  - Cycle +1: index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Cycle +2: index 9 = ac7766f319fadc2128d12941575c006e.
  - Cycle +10: index 1 = a0fafe1788542cb123a339392a6c7605.
  - Cycle +11: index 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Cycle +12: done=1, busy=0.
- Backpressure: repeat with keyReady low for 3 cycles at index 9 -> output stays ac7766f3... with index 9 and valid=1 throughout; index 8 appears exactly 1 cycle after keyReady rises; the full sequence is unchanged.
- start during RUN with a different key -> ignored; the sequence completes with the original key values.
- nRESET asserted asynchronously at index 5 -> all outputs 0 immediately; a new start afterwards produces index 10 = the new lastRoundKey.
- All-zero lastRoundKey -> index 0 output equals the true key whose forward expansion round 10 is zero. Check against a golden forward-expansion model: forward-expand the index-0 output and compare round 10 with lastRoundKey.
- done pulse coincident with start -> done high for 1 cycle, and the next run's index 10 key is valid on the following cycle.

Source files
------------

// File: rtl/inv_key_schedule.sv
// Inverse AES-128 key schedule: walks from the round-10 key back to the
// cipher key, one round key per handshake, using a single 4-wide S-box.
module s_box (
  input  logic [7:0] sboxInput,
  output logic [7:0] sboxOutput
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign sboxOutput = SBOX[sboxInput];
endmodule

module inv_key_schedule #(
  parameter int numKeys = 11
) (
  input  logic         CLK,
  input  logic         nRESET,
  input  logic         start,
  input  logic [127:0] lastRoundKey,
  input  logic         keyReady,
  output logic [127:0] roundKeyOutput,
  output logic         roundKeyValid,
  output logic [3:0]   roundIndex,
  output logic         busy,
  output logic         done
);
  localparam logic [3:0] IDX_MAX = 4'(numKeys - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         done_q, done_d;

  // Rcon used to step from round idx back to idx-1.
  function automatic logic [7:0] rcon_f(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon_f = 8'h01;
      4'd2:    rcon_f = 8'h02;
      4'd3:    rcon_f = 8'h04;
      4'd4:    rcon_f = 8'h08;
      4'd5:    rcon_f = 8'h10;
      4'd6:    rcon_f = 8'h20;
      4'd7:    rcon_f = 8'h40;
      4'd8:    rcon_f = 8'h80;
      4'd9:    rcon_f = 8'h1b;
      4'd10:   rcon_f = 8'h36;
      default: rcon_f = 8'h00;
    endcase
  endfunction

  logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, rot, sub;
  logic [127:0] prev_key;

  assign {w0, w1, w2, w3} = key_q;
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    s_box u_sbox (.sboxInput(rot[8*g +: 8]), .sboxOutput(sub[8*g +: 8]));
  end

  assign p0       = w0 ^ sub ^ {rcon_f(idx_q), 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        key_d   = lastRoundKey;
        idx_d   = IDX_MAX;
        state_d = RUN;
      end
      RUN: if (keyReady) begin
        if (idx_q != 4'd0) begin
          key_d = prev_key;
          idx_d = idx_q - 4'd1;
        end else begin
          // Key 0 taken: hold the last key/index, pulse done.
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign roundKeyOutput = key_q;
  assign roundIndex     = idx_q;
  assign roundKeyValid  = (state_q == RUN);
  assign busy           = (state_q == RUN);
  assign done           = done_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: FIPS-197 A.1 table plus backpressure,
// restart, reset and done/start corner sequences against a forward-expansion model.
module tb_inv_key_schedule;
  logic         CLK = 1'b0;
  logic         nRESET, start, keyReady;
  logic [127:0] lastRoundKey;
  logic [127:0] roundKeyOutput;
  logic         roundKeyValid, busy, done;
  logic [3:0]   roundIndex;

  always #5 CLK = ~CLK;

  inv_key_schedule #(.numKeys(11)) dut (
    .CLK(CLK), .nRESET(nRESET), .start(start), .lastRoundKey(lastRoundKey),
    .keyReady(keyReady), .roundKeyOutput(roundKeyOutput),
    .roundKeyValid(roundKeyValid), .roundIndex(roundIndex),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  vec_t         tbl [11];
  logic [7:0]   sbox_m [256];
  logic [127:0] rk_m [11];
  logic [127:0] got [11];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) r ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return r;
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) then affine map.
  task automatic build_sbox();
    logic [7:0] p, b;
    for (int x = 0; x < 256; x++) begin
      p = 8'h01;
      for (int k = 0; k < 254; k++) p = gmul(p, 8'(x));
      b = p;
      sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic fwd_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic nclk();
    @(negedge CLK);
  endtask

  // Called at a negedge; returns at the negedge where index 10 should be shown.
  task automatic do_start(input logic [127:0] k);
    lastRoundKey = k;
    start = 1'b1;
    nclk();
    start = 1'b0;
  endtask

  task automatic chk_key(input string tag, input int e);
    chk({tag, " valid"}, {127'h0, roundKeyValid}, 128'd1);
    chk({tag, " idx"}, {124'h0, roundIndex}, {124'h0, tbl[e].idx});
    chk({tag, " key"}, roundKeyOutput, tbl[e].key);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, " done"}, {127'h0, done}, 128'd1);
    chk({tag, " busy"}, {127'h0, busy}, 128'd0);
    chk({tag, " valid_low"}, {127'h0, roundKeyValid}, 128'd0);
  endtask

  // Full run at keyReady=1; checks the chain against the forward model.
  task automatic run_collect(input string tag, input logic [127:0] k);
    keyReady = 1'b1;
    do_start(k);
    for (int e = 0; e < 11; e++) begin
      got[10-e] = roundKeyOutput;
      chk({tag, " valid"}, {127'h0, roundKeyValid}, 128'd1);
      chk({tag, " idx"}, {124'h0, roundIndex}, 128'(10 - e));
      nclk();
    end
    chk_done(tag);
    chk({tag, " idx10_is_input"}, got[10], k);
    fwd_expand(got[0]);
    for (int r = 0; r < 11; r++) chk({tag, " fwd_model"}, got[r], rk_m[r]);
    nclk();
  endtask

  initial begin
    tbl[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    tbl[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    tbl[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    tbl[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    tbl[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    tbl[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    tbl[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    tbl[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    build_sbox();

    nRESET = 1'b0; start = 1'b0; keyReady = 1'b0; lastRoundKey = '0;
    nclk(); nclk();
    chk("rst key", roundKeyOutput, 128'h0);
    chk("rst idx", {124'h0, roundIndex}, 128'd0);
    chk("rst valid", {127'h0, roundKeyValid}, 128'd0);
    chk("rst busy", {127'h0, busy}, 128'd0);
    chk("rst done", {127'h0, done}, 128'd0);
    nRESET = 1'b1;
    nclk();

    // A.1 back-to-back
    keyReady = 1'b1;
    do_start(tbl[0].key);
    for (int e = 0; e < 11; e++) begin
      chk_key("a1", e);
      nclk();
    end
    chk_done("a1");
    chk("a1 hold idx", {124'h0, roundIndex}, 128'd0);
    chk("a1 hold key", roundKeyOutput, tbl[10].key);
    nclk();
    chk("a1 done_pulse", {127'h0, done}, 128'd0);

    // Backpressure at index 9
    do_start(tbl[0].key);
    chk_key("bp", 0);
    nclk();
    keyReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_key("bp stall", 1);
      nclk();
    end
    chk_key("bp stall_end", 1);
    keyReady = 1'b1;
    nclk();
    for (int e = 2; e < 11; e++) begin
      chk_key("bp", e);
      nclk();
    end
    chk_done("bp");
    nclk();

    // start during RUN is ignored
    do_start(tbl[0].key);
    for (int e = 0; e < 11; e++) begin
      chk_key("restart", e);
      if (e == 3) begin
        start = 1'b1;
        lastRoundKey = 128'h00112233445566778899aabbccddeeff;
      end else begin
        start = 1'b0;
      end
      nclk();
    end
    start = 1'b0;
    chk_done("restart");
    nclk();

    // Asynchronous reset at index 5
    do_start(tbl[0].key);
    repeat (5) nclk();
    chk_key("arst pre", 5);
    #2 nRESET = 1'b0;
    #1;
    chk("arst key", roundKeyOutput, 128'h0);
    chk("arst idx", {124'h0, roundIndex}, 128'd0);
    chk("arst valid", {127'h0, roundKeyValid}, 128'd0);
    chk("arst busy", {127'h0, busy}, 128'd0);
    nclk();
    nRESET = 1'b1;
    nclk();
    chk("arst no_emit", {127'h0, roundKeyValid}, 128'd0);
    run_collect("post_rst", 128'h000102030405060708090a0b0c0d0e0f);

    // All-zero round-10 key
    run_collect("zero", 128'h0);
    chk("zero fwd_r10", rk_m[10], 128'h0);

    // done coincident with start
    do_start(tbl[0].key);
    repeat (11) nclk();
    chk_done("coinc");
    lastRoundKey = 128'hfeedfacecafebeef0123456789abcdef;
    start = 1'b1;
    nclk();
    start = 1'b0;
    chk("coinc valid", {127'h0, roundKeyValid}, 128'd1);
    chk("coinc idx", {124'h0, roundIndex}, 128'd10);
    chk("coinc key", roundKeyOutput, 128'hfeedfacecafebeef0123456789abcdef);
    chk("coinc done_low", {127'h0, done}, 128'd0);
    repeat (12) nclk();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
